mb_sync_pacer: RTL and testbench
================================

Name: mb_sync_pacer

Overview:
- Source-clock-domain stage placed directly upstream of mb_sync.
- Accepts a bursty producer stream through a valid/ready handshake and buffers it in a small FIFO.
- Re-emits words as single-cycle i_valid pulses to mb_sync, spaced at least MIN_GAP clocks apart.
- Holds the data bus stable between pulses, so every word has settled before the destination domain samples it.

Parameters:
NB, 8, data width in bits (must match mb_sync NB)
MIN_GAP, 10, minimum clocks between successive o_valid pulses; legal range >= 1
DEPTH, 4, FIFO depth in words; power of 2, >= 2

Ports:
i_clock  in  1  source-domain clock (same clock as mb_sync i_src_clock)
i_reset  in  1  asynchronous, active-high reset
i_data  in  NB  producer data word
i_valid  in  1  producer word valid
o_ready  out  1  pacer can accept a word this cycle
o_data  out  NB  paced data word; connects to mb_sync i_data
o_valid  out  1  single-cycle send pulse; connects to mb_sync i_valid
o_level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
o_overflow  out  1  sticky: a word was offered while o_ready was low

Behaviour:
- Clocking and reset
  - One clock: i_clock.
  - Reset is asynchronous and active-high on i_reset.
  - While i_reset is high: o_data=0, o_valid=0, o_level=0, o_overflow=0, o_ready=1 (combinational from empty FIFO), FIFO pointers=0, gap counter=0.
- Write side
  - Accept when i_valid && o_ready at a rising edge; word stored at wr_ptr, wr_ptr++ mod DEPTH.
  - o_ready = (o_level != DEPTH). It is derived from registered level only, with no same-cycle pop bypass. When full, o_ready stays low even if a pop occurs that edge.
  - i_valid && !o_ready: word discarded, o_overflow set to 1, held until reset.
- Gap counter, width $clog2(MIN_GAP+1)
  - Loaded with MIN_GAP-1 on each send.
  - Otherwise decrements while nonzero.
- Send condition: FIFO non-empty (registered level > 0) && gap counter == 0.
- FSM states
  - IDLE: empty, gap == 0.
  - SEND: pop this edge.
  - WAIT: gap != 0.
  - Transitions: IDLE->SEND on non-empty; SEND->WAIT when MIN_GAP>1, else SEND->SEND/IDLE; WAIT->SEND when gap reaches 0 and non-empty; WAIT->IDLE when gap reaches 0 and empty.
- On send edge
  - o_data <= FIFO[rd_ptr]; rd_ptr++ mod DEPTH; o_valid <= 1 for exactly one cycle.
  - o_data then holds that value until the next send.
- Latency and spacing
  - Word accepted at edge N into an empty FIFO with gap expired: o_valid high after edge N+1 (one-cycle latency).
  - Pulses at edges t and t' satisfy t' - t >= MIN_GAP, with equality when the FIFO stays non-empty.
- Simultaneous write and pop: level unchanged (+1-1); pointers both advance; ordering strictly FIFO.
- o_level update each edge: +1 on accepted write, -1 on pop, net 0 if both.
- Reset mid-operation
  - Queued words lost, o_data cleared, gap counter cleared.
  - The first word after release is sent without waiting out a prior gap.
- No combinational path from i_data/i_valid to o_data/o_valid.

Test Plan (NB=8, MIN_GAP=10, DEPTH=4):
1. Single word: write 0xA5 at edge 5 -> o_valid high for one cycle after edge 6, o_data=0xA5 and held thereafter; o_level 1 then 0.
2. Burst: 0x01..0x04 on consecutive edges 0..3 -> pulses at edges 1, 11, 21, 31; data 0x01, 0x02, 0x03, 0x04 in order; o_overflow stays 0.
3. Overflow: 0x10..0x15 on edges 0..5 -> o_level reaches 4 at edge 4; o_ready low at edge 5; 0x15 dropped, o_overflow=1 sticky; outputs 0x10..0x14 spaced 10 apart.
4. Reset mid-operation: 3 words queued, pulse i_reset between edges -> o_data=0, o_level=0 immediately. After release, write 0x3C -> o_valid one cycle later, no gap wait.
5. Gap boundary: pulse at edge 20 with FIFO empty; write 0x77 at edge 29 -> pulse at edge 30 (exactly MIN_GAP); write at edge 25 -> also pulse at edge 30, not earlier.
6. System: pacer feeding mb_sync with src period 4, dest period 10, 200 random words -> mb_sync o_data sequence equals pacer output sequence, with no torn/intermediate values.

Source files
------------

// File: rtl/mb_sync_pacer.sv
// -----------------------------------------------------------------------------
// mb_sync_pacer
//
// Source-domain pacing stage that sits in front of mb_sync. A bursty producer
// pushes words through a valid/ready handshake into a small FIFO. The pacer
// re-emits those words as single-cycle o_valid pulses that are at least
// MIN_GAP clocks apart. o_data is registered and only changes on a send, so
// each word stays stable long enough for the destination domain to sample it.
//
// Ports
//   i_clock    : source-domain clock (same clock as mb_sync i_src_clock)
//   i_reset    : asynchronous, active-high reset
//   i_data     : producer data word
//   i_valid    : producer word valid
//   o_ready    : pacer can accept a word this cycle (registered level != DEPTH)
//   o_data     : paced data word, held between sends (to mb_sync i_data)
//   o_valid    : single-cycle send pulse (to mb_sync i_valid)
//   o_level    : FIFO occupancy, 0..DEPTH
//   o_overflow : sticky flag, a word was offered while o_ready was low
// -----------------------------------------------------------------------------
module mb_sync_pacer #(
  parameter int NB      = 8,
  parameter int MIN_GAP = 10,
  parameter int DEPTH   = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NB-1:0]            i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [NB-1:0]            o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(MIN_GAP + 1);

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(MIN_GAP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [NB-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level_q;
  logic [LW-1:0]   level_d;
  logic [GW-1:0]   gap_q;
  logic [GW-1:0]   gap_d;
  logic            overflow_q;

  logic            wr_en;
  logic            pop;

  logic [NB-1:0]   data_p1;
  logic            vld_p1;

  // Ready comes from the registered level only: a pop on the same edge does
  // not reopen a full FIFO, which keeps i_valid -> o_ready free of any path.
  assign o_ready = (level_q != LEVEL_FULL);
  assign wr_en   = i_valid && o_ready;

  // The state register mirrors (level, gap) exactly, so SEND means "FIFO
  // non-empty and gap expired" for the current cycle and the pop is taken
  // at the end of it.
  assign pop     = (state_q == SEND);

  always_comb begin
    level_d = level_q;
    gap_d   = gap_q;
    state_d = state_q;

    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (pop) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end

    case (state_q)
      IDLE: begin
        if (level_d != '0) state_d = SEND;
        else               state_d = IDLE;
      end
      SEND, WAIT: begin
        // With MIN_GAP == 1 the load value is 0, so SEND can chain to SEND.
        if (gap_d != '0)        state_d = WAIT;
        else if (level_d != '0) state_d = SEND;
        else                    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      level_q    <= '0;
      gap_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      gap_q   <= gap_d;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (i_valid && !o_ready) overflow_q <= 1'b1;
    end
  end

  // FIFO storage has no reset; occupancy is tracked by level/pointers.
  always_ff @(posedge i_clock) begin
    if (wr_en) mem[wr_ptr] <= i_data;
  end

  // ---- stage p1: registered send pulse and held output word ----
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= pop;
      if (pop) data_p1 <= mem[rd_ptr];
    end
  end

  assign o_data     = data_p1;
  assign o_valid    = vld_p1;
  assign o_level    = level_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_mb_sync_pacer.sv
// -----------------------------------------------------------------------------
// tb_mb_sync_pacer
//
// Directed bench for mb_sync_pacer (NB=8, MIN_GAP=10, DEPTH=4). Inputs are
// driven 1 time unit after a rising edge; outputs are sampled at the same
// point, i.e. reflecting the edge just taken. "Edge e" in the burst runs is
// the e-th rising edge counted from the start of that run.
// -----------------------------------------------------------------------------
module tb_mb_sync_pacer;

  localparam int NB      = 8;
  localparam int MIN_GAP = 10;
  localparam int DEPTH   = 4;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [NB-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic [NB-1:0] o_data;
  logic          o_valid;
  logic [LW-1:0] o_level;
  logic          o_overflow;

  int errors = 0;
  int checks = 0;

  mb_sync_pacer #(
    .NB      (NB),
    .MIN_GAP (MIN_GAP),
    .DEPTH   (DEPTH)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_level    (o_level),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Burst-run capture
  int        pulse_e[$];
  logic [7:0] pulse_d[$];
  logic [LW-1:0] lvl_hist[64];
  logic      rdy_hist[64];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer base+e on edges 0..n_wr-1, then idle; record level/ready and pulses.
  task automatic run_burst(input logic [7:0] base, input int n_wr, input int n_edges);
    pulse_e.delete();
    pulse_d.delete();
    for (int e = 0; e < n_edges; e++) begin
      i_valid     = (e < n_wr);
      i_data      = base + 8'(e);
      rdy_hist[e] = o_ready;
      tick();
      lvl_hist[e] = o_level;
      if (o_valid) begin
        pulse_e.push_back(e);
        pulse_d.push_back(o_data);
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic chk_pulses(input string tag, input logic [7:0] base, input int n);
    chk({tag, "_count"}, 32'(pulse_e.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < pulse_e.size()) begin
        chk({tag, "_edge"}, 32'(pulse_e[i]), 32'(1 + MIN_GAP * i));
        chk({tag, "_data"}, 32'(pulse_d[i]), 32'(base + 8'(i)));
      end else begin
        chk({tag, "_missing"}, 32'hFFFF_FFFF, 32'(i));
      end
    end
  endtask

  initial begin : stim
    logic          early;
    logic [NB-1:0] sb[$];
    logic [NB-1:0] held;
    logic [NB-1:0] exp_w;
    int            cyc;
    int            last_cyc;
    int            sent;
    int            rx;
    int            unstable;

    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;

    // Reset values
    tick();
    tick();
    chk("rst_o_data",     32'(o_data),     32'h0);
    chk("rst_o_valid",    32'(o_valid),    32'h0);
    chk("rst_o_level",    32'(o_level),    32'h0);
    chk("rst_o_overflow", 32'(o_overflow), 32'h0);
    chk("rst_o_ready",    32'(o_ready),    32'h1);
    rst = 1'b0;
    tick();

    // Single word: one-cycle latency, data held afterwards
    i_valid = 1'b1;
    i_data  = 8'hA5;
    tick();
    chk("single_level_after_wr", 32'(o_level), 32'd1);
    chk("single_no_early_valid", 32'(o_valid), 32'd0);
    i_valid = 1'b0;
    tick();
    chk("single_valid",        32'(o_valid), 32'd1);
    chk("single_data",         32'(o_data),  32'hA5);
    chk("single_level_popped", 32'(o_level), 32'd0);
    tick();
    chk("single_valid_one_cycle", 32'(o_valid), 32'd0);
    chk("single_data_held",       32'(o_data),  32'hA5);
    repeat (12) tick();

    // Burst of four: pulses at edges 1, 11, 21, 31
    run_burst(8'h01, 4, 45);
    chk_pulses("burst", 8'h01, 4);
    chk("burst_no_overflow", 32'(o_overflow), 32'd0);
    chk("burst_level_end",   32'(o_level),    32'd0);

    // Overflow: six words into a four-deep FIFO; the sixth is dropped
    run_burst(8'h10, 6, 52);
    chk("ovf_level_full_e4",  32'(lvl_hist[4]), 32'd4);
    chk("ovf_ready_high_e4",  32'(rdy_hist[4]), 32'd1);
    chk("ovf_ready_low_e5",   32'(rdy_hist[5]), 32'd0);
    chk_pulses("ovf", 8'h10, 5);
    chk("ovf_sticky",         32'(o_overflow), 32'd1);
    chk("ovf_level_end",      32'(o_level),    32'd0);

    // Reset mid-operation, then first word goes out without a gap wait
    i_valid = 1'b1;
    i_data  = 8'h31; tick();
    i_data  = 8'h32; tick();
    i_data  = 8'h33; tick();
    i_valid = 1'b0;
    tick();
    chk("mid_data_before_rst",  32'(o_data),  32'h31);
    chk("mid_level_before_rst", 32'(o_level), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_o_data",     32'(o_data),     32'h0);
    chk("mid_rst_o_level",    32'(o_level),    32'h0);
    chk("mid_rst_o_overflow", 32'(o_overflow), 32'h0);
    chk("mid_rst_o_ready",    32'(o_ready),    32'h1);
    #1 rst = 1'b0;
    i_valid = 1'b1;
    i_data  = 8'h3C;
    tick();
    i_valid = 1'b0;
    chk("post_rst_no_early", 32'(o_valid), 32'd0);
    tick();
    chk("post_rst_valid", 32'(o_valid), 32'd1);
    chk("post_rst_data",  32'(o_data),  32'h3C);

    // Gap boundary: word written 9 edges after a pulse goes out at +10
    early = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 9) begin
        i_valid = 1'b1;
        i_data  = 8'h77;
      end
      tick();
      i_valid = 1'b0;
      if (o_valid) early = 1'b1;
    end
    chk("gap9_no_early", 32'(early),   32'd0);
    chk("gap9_level",    32'(o_level), 32'd1);
    tick();
    chk("gap9_valid", 32'(o_valid), 32'd1);
    chk("gap9_data",  32'(o_data),  32'h77);

    // Word written 5 edges after a pulse must still wait to +10
    early = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 5) begin
        i_valid = 1'b1;
        i_data  = 8'h78;
      end
      tick();
      i_valid = 1'b0;
      if (o_valid) early = 1'b1;
    end
    chk("gap5_no_early",  32'(early),   32'd0);
    chk("gap5_data_held", 32'(o_data),  32'h77);
    tick();
    chk("gap5_valid", 32'(o_valid), 32'd1);
    chk("gap5_data",  32'(o_data),  32'h78);
    repeat (12) tick();

    // Random stream: order preserved, spacing >= MIN_GAP, data stable between pulses
    sent     = 0;
    rx       = 0;
    cyc      = 0;
    last_cyc = 0;
    unstable = 0;
    held     = o_data;
    while (rx < 200 && cyc < 6000) begin
      i_valid = (sent < 200) && o_ready && ($urandom_range(0, 1) == 0);
      i_data  = NB'($urandom_range(0, 255));
      if (i_valid) begin
        sb.push_back(i_data);
        sent++;
      end
      tick();
      cyc++;
      i_valid = 1'b0;
      if (o_valid) begin
        exp_w = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        chk("stream_data", 32'(o_data), 32'(exp_w));
        if (rx > 0) begin
          checks++;
          assert (cyc - last_cyc >= MIN_GAP) else begin
            errors++;
            $error("FAIL stream_spacing: observed=%0d expected>=%0d", cyc - last_cyc, MIN_GAP);
          end
        end
        last_cyc = cyc;
        held     = o_data;
        rx++;
      end else if (o_data !== held) begin
        unstable++;
      end
    end
    chk("stream_rx_count",    32'(rx),         32'd200);
    chk("stream_data_stable", 32'(unstable),   32'd0);
    chk("stream_no_overflow", 32'(o_overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
